l1_pte_cache: RTL and testbench
===============================

L1_PTE_CACHE -- requirements
Module: l1_pte_cache

Interface
REQ-001 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-003 SHALL have port l1_va_i  input  28  walker PTE byte address; bits [1:0] ignored.
REQ-004 SHALL have port l1_va_vld_i  input  1  request valid.
REQ-005 SHALL have port l1_cancel_i  input  1  cancels the request accepted in the previous cycle.
REQ-006 SHALL have port l1_pa_o  output  32  returned PTE word.
REQ-007 SHALL have port l1_vld_o  output  1  l1_pa_o valid, one-cycle pulse per response.
REQ-008 SHALL have port stall_o  output  1  requester must hold; no request accepted while high.
REQ-009 SHALL have ports mem_addr_o  output  28  (word-aligned refill address), mem_req_o  output  1, and mem_gnt_i  input  1.
REQ-010 SHALL have ports mem_data_i  input  32 and mem_data_vld_i  input  1  (refill return).
REQ-011 SHALL have port flush_i  input  1  invalidates all entries.

Function
REQ-012 SHALL be a 16-entry direct-mapped cache: index = va[5:2], tag = va[27:6] (22 bits), plus a valid bit per entry.
REQ-013 SHALL accept a request in cycle T when l1_va_vld_i=1 and stall_o=0, registering it into stage S1.
REQ-014 SHALL perform the tag lookup in S1 (T+1); a request with l1_cancel_i=1 in T+1 is dropped: no response, no refill.
REQ-015 SHALL, on an uncancelled hit, drive l1_vld_o=1 with the entry data in T+2 (fixed 2-cycle hit latency).
REQ-016 SHALL drive stall_o combinationally high when S1 holds an uncancelled miss, or when the FSM is not IDLE.
REQ-017 SHALL implement FSM IDLE->REQ on an uncancelled S1 miss, REQ->WAIT on mem_gnt_i=1, WAIT->IDLE on mem_data_vld_i=1.
REQ-018 SHALL hold mem_req_o=1 and mem_addr_o={va[27:2],2'b00} throughout REQ; both SHALL be stable until the grant.
REQ-019 SHALL, on mem_data_vld_i in WAIT, write data, tag and valid into the indexed entry; drive l1_vld_o=1 with that data next cycle; drop stall_o in that same next cycle.
REQ-020 SHALL ignore mem_gnt_i outside REQ and mem_data_vld_i outside WAIT.
REQ-021 SHALL ignore l1_cancel_i when S1 is empty and during REQ/WAIT.
REQ-022 SHALL clear all valid bits on flush_i at the clock edge.
REQ-023 SHALL use pre-flush state for an S1 lookup in the flush cycle.
REQ-024 SHALL still write a refill whose data arrives in or after the flush cycle.
REQ-025 SHALL let a refill write in the same cycle as an S1 lookup of the same index; the lookup sees the old contents.
REQ-026 SHALL hold l1_pa_o at its last value when l1_vld_o=0.

Reset
REQ-027 SHALL, on reset_i=1, clear all valid bits and S1, and force the FSM to IDLE.
REQ-028 SHALL drive the following outputs to 0 in the cycle after reset: l1_vld_o, stall_o, mem_req_o, mem_addr_o, l1_pa_o.
REQ-029 SHALL, on reset mid-refill, abandon the refill; later mem_data_vld_i SHALL be ignored.

Configuration
REQ-030 SHALL, with macro L1_PTE_CACHE_STATS_EN defined, add outputs hit_cnt_o[15:0] and miss_cnt_o[15:0].
REQ-031 SHALL make those counters count uncancelled S1 hits/misses, saturate at 16'hFFFF, and reset to 0.
REQ-032 SHALL, without L1_PTE_CACHE_STATS_EN, have neither counter port and no counter logic; all other behaviour is identical.

Verification
REQ-033 Cold miss: reset, request 28'h0000040, mem_gnt_i after 2 cycles, mem_data_i=32'hDEADBEEF -> mem_req_o with mem_addr_o=28'h0000040; l1_pa_o=32'hDEADBEEF one cycle after data; stall_o low that same cycle.
REQ-034 Hit: repeat 28'h0000040 -> l1_vld_o=1, l1_pa_o=32'hDEADBEEF exactly 2 cycles after acceptance; mem_req_o stays 0.
REQ-035 Cancel: miss on 28'h0000080 with l1_cancel_i=1 the next cycle -> no mem_req_o, no l1_vld_o, stall_o never high.
REQ-036 Back-to-back hits on 28'h40, 28'h44, 28'h48 in consecutive cycles (all filled) -> three consecutive l1_vld_o pulses, in order.
REQ-037 Conflict and flush: fill 28'h0000040, then request 28'h0000440 (same index) -> miss and refill; after flush_i, 28'h0000440 -> miss.
REQ-038 Reset in WAIT, then mem_data_vld_i=1 -> no write, no l1_vld_o; the next request to the same address misses.

Source files
------------

// File: rtl/l1_pte_cache.sv
// 16-entry direct-mapped PTE cache for the page walker; optional hit/miss counters under L1_PTE_CACHE_STATS_EN.
// Hits return 2 cycles after acceptance; a miss stalls the requester until the refill word is returned.
module l1_pte_cache (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [27:0] l1_va_i,
  input  logic        l1_va_vld_i,
  input  logic        l1_cancel_i,
  output logic [31:0] l1_pa_o,
  output logic        l1_vld_o,
  output logic        stall_o,
  output logic [27:0] mem_addr_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_data_vld_i,
`ifdef L1_PTE_CACHE_STATS_EN
  input  logic        flush_i,
  output logic [15:0] hit_cnt_o,
  output logic [15:0] miss_cnt_o
`else
  input  logic        flush_i
`endif
);

  typedef struct packed {
    logic        vld;
    logic [21:0] tag;
    logic [31:0] dat;
  } pte_entry_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  pte_entry_t  entries [16];
  state_t      state;
  logic        s1_vld;
  logic [27:2] s1_va;
  logic        accept;
  logic [3:0]  s1_idx;
  logic [21:0] s1_tag;
  pte_entry_t  s1_ent;
  logic        s1_live;
  logic        s1_hit;
  logic        s1_miss;
  logic        rf_fire;
  logic [3:0]  rf_idx;
  logic [21:0] rf_tag;
  logic        unused_va_bits;

  assign unused_va_bits = ^l1_va_i[1:0];

  assign accept  = l1_va_vld_i && !stall_o;
  assign s1_idx  = s1_va[5:2];
  assign s1_tag  = s1_va[27:6];
  assign s1_ent  = entries[s1_idx];
  assign s1_live = s1_vld && !l1_cancel_i;
  assign s1_hit  = s1_ent.vld && (s1_ent.tag == s1_tag);
  assign s1_miss = s1_live && !s1_hit;

  // The refill address register stays stable through WAIT, so it also names the entry to fill.
  assign rf_fire = (state == WAIT) && mem_data_vld_i;
  assign rf_idx  = mem_addr_o[5:2];
  assign rf_tag  = mem_addr_o[27:6];

  assign stall_o = s1_miss || (state != IDLE);

  // Refill write is ordered after the flush so a refill landing in the flush cycle survives.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 16; i++) entries[i].vld <= 1'b0;
    end else begin
      if (flush_i) begin
        for (int i = 0; i < 16; i++) entries[i].vld <= 1'b0;
      end
      if (rf_fire) begin
        entries[rf_idx] <= '{vld: 1'b1, tag: rf_tag, dat: mem_data_i};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_vld     <= 1'b0;
      s1_va      <= '0;
      state      <= IDLE;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      l1_vld_o   <= 1'b0;
      l1_pa_o    <= '0;
    end else begin
      s1_vld   <= accept;
      l1_vld_o <= 1'b0;
      if (accept) s1_va <= l1_va_i[27:2];
      case (state)
        IDLE: begin
          if (s1_miss) begin
            state      <= REQ;
            mem_req_o  <= 1'b1;
            mem_addr_o <= {s1_va, 2'b00};
          end else if (s1_live && s1_hit) begin
            l1_vld_o <= 1'b1;
            l1_pa_o  <= s1_ent.dat;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            state     <= WAIT;
            mem_req_o <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_data_vld_i) begin
            state    <= IDLE;
            l1_vld_o <= 1'b1;
            l1_pa_o  <= mem_data_i;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef L1_PTE_CACHE_STATS_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (s1_live && s1_hit && (hit_cnt_o != 16'hFFFF)) hit_cnt_o <= hit_cnt_o + 16'd1;
      if (s1_miss && (miss_cnt_o != 16'hFFFF)) miss_cnt_o <= miss_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l1_pte_cache.sv
// Scoreboard bench for l1_pte_cache: expected responses queued at stimulus time, checked on l1_vld_o.
module tb_l1_pte_cache;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [27:0] l1_va_i = '0;
  logic        l1_va_vld_i = 1'b0;
  logic        l1_cancel_i = 1'b0;
  logic [31:0] l1_pa_o;
  logic        l1_vld_o;
  logic        stall_o;
  logic [27:0] mem_addr_o;
  logic        mem_req_o;
  logic        mem_gnt_i = 1'b0;
  logic [31:0] mem_data_i = '0;
  logic        mem_data_vld_i = 1'b0;
  logic        flush_i = 1'b0;

  l1_pte_cache dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .l1_va_i        (l1_va_i),
    .l1_va_vld_i    (l1_va_vld_i),
    .l1_cancel_i    (l1_cancel_i),
    .l1_pa_o        (l1_pa_o),
    .l1_vld_o       (l1_vld_o),
    .stall_o        (stall_o),
    .mem_addr_o     (mem_addr_o),
    .mem_req_o      (mem_req_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_data_i     (mem_data_i),
    .mem_data_vld_i (mem_data_vld_i),
    .flush_i        (flush_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] dat;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q [$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned mem_req_seen = 0;
  int unsigned stall_seen = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Outputs are sampled on the falling edge, clear of the register updates.
  always @(negedge clk_i) begin
    exp_t e;
    if (mem_req_o === 1'b1) mem_req_seen++;
    if (stall_o === 1'b1) stall_seen++;
    if (l1_vld_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_vld", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", {32'd0, l1_pa_o}, {32'd0, e.dat});
        chk("rsp_cycle", {32'd0, cyc}, {32'd0, e.cyc});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_req(input logic [27:0] va, input bit hit, input logic [31:0] dat);
    chk("stall_before_req", {63'd0, stall_o}, 64'd0);
    l1_va_i     = va;
    l1_va_vld_i = 1'b1;
    if (hit) exp_q.push_back('{dat: dat, cyc: cyc + 2});
    tick();
    l1_va_vld_i = 1'b0;
  endtask

  task automatic chk_req(input logic [27:0] va);
    logic [27:0] exp_addr;
    exp_addr = {va[27:2], 2'b00};
    @(negedge clk_i);
    chk("mem_req", {63'd0, mem_req_o}, 64'd1);
    chk("mem_addr", {36'd0, mem_addr_o}, {36'd0, exp_addr});
  endtask

  task automatic do_miss(input logic [27:0] va, input logic [31:0] dat, input int gnt_dly);
    do_req(va, 1'b0, '0);
    @(negedge clk_i);
    chk("miss_stall", {63'd0, stall_o}, 64'd1);
    tick();
    for (int i = 0; i < gnt_dly; i++) begin
      chk_req(va);
      tick();
    end
    mem_gnt_i = 1'b1;
    chk_req(va);
    tick();
    mem_gnt_i      = 1'b0;
    mem_data_i     = dat;
    mem_data_vld_i = 1'b1;
    exp_q.push_back('{dat: dat, cyc: cyc + 1});
    @(negedge clk_i);
    chk("req_dropped_in_wait", {63'd0, mem_req_o}, 64'd0);
    tick();
    mem_data_vld_i = 1'b0;
    @(negedge clk_i);
    chk("stall_after_refill", {63'd0, stall_o}, 64'd0);
    tick();
  endtask

  initial begin
    int unsigned s0;
    int unsigned m0;

    repeat (3) tick();
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("rst_vld", {63'd0, l1_vld_o}, 64'd0);
    chk("rst_stall", {63'd0, stall_o}, 64'd0);
    chk("rst_req", {63'd0, mem_req_o}, 64'd0);
    chk("rst_addr", {36'd0, mem_addr_o}, 64'd0);
    chk("rst_pa", {32'd0, l1_pa_o}, 64'd0);
    tick();

    // Cold miss, grant two cycles into REQ.
    do_miss(28'h0000040, 32'hDEADBEEF, 2);

    // Hit with stray grant/data pulses that must be ignored outside REQ/WAIT.
    m0 = mem_req_seen;
    mem_gnt_i = 1'b1; mem_data_vld_i = 1'b1; mem_data_i = 32'hBAD0BAD0;
    do_req(28'h0000040, 1'b1, 32'hDEADBEEF);
    repeat (3) tick();
    mem_gnt_i = 1'b0; mem_data_vld_i = 1'b0;
    chk("hit_no_mem_req", {32'd0, mem_req_seen - m0}, 64'd0);
    @(negedge clk_i);
    chk("pa_hold", {32'd0, l1_pa_o}, {32'd0, 32'hDEADBEEF});
    tick();

    // Cancelled miss: no stall seen, no refill, no response.
    s0 = stall_seen; m0 = mem_req_seen;
    do_req(28'h0000080, 1'b0, '0);
    l1_cancel_i = 1'b1;
    tick();
    l1_cancel_i = 1'b0;
    repeat (4) tick();
    chk("cancel_stall", {32'd0, stall_seen - s0}, 64'd0);
    chk("cancel_req", {32'd0, mem_req_seen - m0}, 64'd0);

    // Fill neighbours, then three back-to-back hits.
    do_miss(28'h0000044, 32'hA1A1A1A1, 0);
    do_miss(28'h0000048, 32'hA2A2A2A2, 1);
    do_req(28'h0000040, 1'b1, 32'hDEADBEEF);
    do_req(28'h0000044, 1'b1, 32'hA1A1A1A1);
    do_req(28'h0000048, 1'b1, 32'hA2A2A2A2);
    repeat (3) tick();

    // Conflict on index 0 evicts 0x40; a flush in the lookup cycle still hits on old state.
    do_miss(28'h0000440, 32'hC0FFEE00, 1);
    do_req(28'h0000044, 1'b1, 32'hA1A1A1A1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    repeat (2) tick();
    do_miss(28'h0000440, 32'h13572468, 0);

    // Reset while waiting for refill data; the late data must be dropped.
    do_req(28'h0000100, 1'b0, '0);
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("rst_wait_stall", {63'd0, stall_o}, 64'd0);
    chk("rst_wait_req", {63'd0, mem_req_o}, 64'd0);
    chk("rst_wait_pa", {32'd0, l1_pa_o}, 64'd0);
    tick();
    mem_data_i = 32'h55555555; mem_data_vld_i = 1'b1;
    tick();
    mem_data_vld_i = 1'b0;
    repeat (2) tick();
    do_miss(28'h0000100, 32'h600D600D, 0);

    repeat (3) tick();
    chk("queue_drained", {32'd0, exp_q.size()}, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
